seq_alu: RTL and testbench

Parametrised, registered successor to the lab's combinational 32-bit ALU. It keeps the same operand-inversion and op-select encoding and the same {V,C,N,Z} status word. It adds a valid/ready handshake, registered results, iterative bit-serial shifters with a new arithmetic-right-shift op, and a stored carry flag so multi-word adds can be chained. It sits between the operand register file and the writeback/status register in the datapath.

---
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake, bit-serial shifters
// and a stored carry flag for chaining multi-word additions.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             use_flag_c,
  input  logic [4:0]       select_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = 1;

  localparam logic [2:0] OP_XOR = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   cnt;
  logic [2:0]       shop;
  logic             flag_c;

  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [SHW-1:0]   amt;
  logic [2:0]       op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             is_shift;
  logic [WIDTH-1:0] imm_f;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] next_sh;
  logic             next_c;

  assign op       = select_in[2:0];
  assign a_out    = select_in[4] ? ~A : A;
  assign b_out    = select_in[3] ? ~B : B;
  assign amt      = B[SHW-1:0];
  assign cin      = use_flag_c ? flag_c : Cin;
  assign sum      = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin};
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle result for logic ops, ADD and shift-by-zero
  always_comb begin
    imm_f = '0;
    imm_c = 1'b0;
    imm_v = 1'b0;
    case (op)
      OP_XOR: imm_f = a_out ^ b_out;
      OP_AND: imm_f = a_out & b_out;
      OP_OR:  imm_f = a_out | b_out;
      OP_NOR: imm_f = ~(a_out | b_out);
      OP_ADD: begin
        imm_f = sum[WIDTH-1:0];
        imm_c = sum[WIDTH];
        imm_v = ~(a_out[WIDTH-1] ^ b_out[WIDTH-1]) & (sum[WIDTH-1] ^ a_out[WIDTH-1]);
      end
      default: imm_f = a_out;
    endcase
  end

  // One bit-serial shift step; the carry is the bit falling off the end
  always_comb begin
    next_sh = shreg;
    next_c  = 1'b0;
    case (shop)
      OP_SLL: begin
        next_sh = {shreg[WIDTH-2:0], 1'b0};
        next_c  = shreg[WIDTH-1];
      end
      OP_SRL: begin
        next_sh = {1'b0, shreg[WIDTH-1:1]};
        next_c  = shreg[0];
      end
      default: begin
        next_sh = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        next_c  = shreg[0];
      end
    endcase
  end

  // Control FSM plus result, status and carry-flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      F      <= '0;
      status <= 4'b0000;
      flag_c <= 1'b0;
      cnt    <= '0;
      shreg  <= '0;
      shop   <= OP_SRA;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (amt != '0)) begin
              shreg <= a_out;
              cnt   <= amt;
              shop  <= op;
              state <= SHIFT;
            end else begin
              F      <= imm_f;
              status <= {imm_v, imm_c, imm_f[WIDTH-1], (imm_f == '0)};
              if (op == OP_ADD) begin
                flag_c <= sum[WIDTH];
              end
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg <= next_sh;
          cnt   <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            F      <= next_sh;
            status <= {1'b0, next_c, next_sh[WIDTH-1], (next_sh == '0)};
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu at WIDTH = 32.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        use_flag_c;
  logic [4:0]  select_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] F;
  logic [3:0]  status;

  typedef struct {
    logic [31:0] f;
    logic [3:0]  st;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .Cin        (Cin),
    .use_flag_c (use_flag_c),
    .select_in  (select_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .F          (F),
    .status     (status)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation through the accept edge; optionally queue its expected result
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c,
                               input logic uf, input logic [4:0] sel, input bit push,
                               input logic [31:0] ef, input logic [3:0] est,
                               input int elat, input string tag);
    exp_t e;
    A = a; B = b; Cin = c; use_flag_c = uf; select_in = sel;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'b0; use_flag_c = 1'b0; select_in = 5'($urandom);
    if (push) begin
      e.f = ef; e.st = est; e.lat = elat; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for the result, compare against the scoreboard, optionally stall, then hand off
  task automatic checkOutput(input int hold);
    exp_t e;
    int   lat;
    bit   ready_bad;
    lat = 0;
    ready_bad = 1'b0;
    do begin
      if (in_ready !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    if (in_ready !== 1'b0) ready_bad = 1'b1;
    e = sb.pop_front();
    checkEq({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    checkEq({e.tag, "_busy"}, {31'd0, ready_bad}, 32'd0);
    checkEq({e.tag, "_F"}, F, e.f);
    checkEq({e.tag, "_status"}, {28'd0, status}, {28'd0, e.st});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkEq({e.tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      checkEq({e.tag, "_hold_F"}, F, e.f);
      checkEq({e.tag, "_hold_status"}, {28'd0, status}, {28'd0, e.st});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkEq({e.tag, "_handoff"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  // Directed test sequence
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; use_flag_c = 1'b0; select_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkEq("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkEq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("reset_F", F, 32'd0);
    checkEq("reset_status", {28'd0, status}, 32'd0);

    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 5'b00100, 1, 32'h00000000, 4'b0101, 1, "add_wrap");
    checkOutput(0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 5'b00100, 1, 32'h00000001, 4'b0000, 1, "add_chain");
    checkOutput(0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0, 5'b01100, 1, 32'hFFFFFFFE, 4'b0010, 1, "sub");
    checkOutput(0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 5'b00100, 1, 32'h80000000, 4'b1010, 1, "add_ovf");
    checkOutput(0);
    applyStimulus(32'h80000000, 32'd4, 1'b0, 1'b0, 5'b00111, 1, 32'hF8000000, 4'b0010, 4, "sra4");
    checkOutput(0);
    applyStimulus(32'h80000001, 32'd1, 1'b0, 1'b0, 5'b00101, 1, 32'h00000002, 4'b0100, 1, "sll1");
    checkOutput(0);
    applyStimulus(32'h12345678, 32'd0, 1'b0, 1'b0, 5'b00101, 1, 32'h12345678, 4'b0000, 1, "sll0");
    checkOutput(0);

    applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 5'b00000, 1, 32'h0FF00FF0, 4'b0000, 1, "xor");
    checkOutput(0);
    applyStimulus(32'h0000FFFF, 32'h12345678, 1'b0, 1'b0, 5'b10001, 1, 32'h12340000, 4'b0000, 1, "and_inva");
    checkOutput(0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'b00010, 1, 32'h00000000, 4'b0001, 1, "or_zero");
    checkOutput(0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'b00011, 1, 32'hFFFFFFFF, 4'b0010, 1, "nor");
    checkOutput(0);
    applyStimulus(32'h00000003, 32'd1, 1'b0, 1'b0, 5'b00110, 1, 32'h00000001, 4'b0100, 1, "srl1");
    checkOutput(0);
    applyStimulus(32'h40000000, 32'd31, 1'b0, 1'b0, 5'b00111, 1, 32'h00000000, 4'b0101, 31, "sra31");
    checkOutput(0);
    applyStimulus(32'h00000001, 32'd3, 1'b0, 1'b0, 5'b01101, 1, 32'h00000008, 4'b0000, 3, "sll_invb");
    checkOutput(0);
    applyStimulus(32'h00000010, 32'hFFFFFFE4, 1'b0, 1'b0, 5'b00110, 1, 32'h00000001, 4'b0000, 4, "srl_amt");
    checkOutput(0);

    // Carry flag survives a non-ADD op between chained adds
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 5'b00100, 1, 32'h00000000, 4'b0101, 1, "add_wrap2");
    checkOutput(0);
    applyStimulus(32'h0000000F, 32'h00000003, 1'b0, 1'b0, 5'b00001, 1, 32'h00000003, 4'b0000, 1, "and_mid");
    checkOutput(0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 5'b00100, 1, 32'h00000001, 4'b0000, 1, "add_flag_held");
    checkOutput(0);

    // Backpressure: result held while out_ready stays low
    applyStimulus(32'h00000100, 32'h00000023, 1'b0, 1'b0, 5'b00100, 1, 32'h00000123, 4'b0000, 1, "stall");
    checkOutput(10);

    // Reset mid-shift with a set carry flag and a nonzero F
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 5'b00100, 1, 32'h00000000, 4'b0101, 1, "add_wrap3");
    checkOutput(0);
    applyStimulus(32'hA5A5A5A5, 32'd0, 1'b0, 1'b0, 5'b00000, 1, 32'hA5A5A5A5, 4'b0010, 1, "xor_pre");
    checkOutput(0);
    applyStimulus(32'hFFFFFFFF, 32'd20, 1'b0, 1'b0, 5'b00110, 0, 32'd0, 4'd0, 0, "srl20");
    repeat (5) @(posedge clk);
    #1;
    checkEq("midshift_busy", {30'd0, in_ready, out_valid}, 32'b00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkEq("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    checkEq("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("rst2_F", F, 32'd0);
    checkEq("rst2_status", {28'd0, status}, 32'd0);
    applyStimulus(32'd0, 32'd0, 1'b1, 1'b1, 5'b00100, 1, 32'h00000000, 4'b0001, 1, "add_after_rst");
    checkOutput(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
